// File: rtl/vram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vram_arbiter: single-port VRAM arbiter, scan-out fetcher vs. one-entry CPU op buffer.
// Revision: 1.0
// ---------------------------------------------------------------------------
module vram_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic              buf_valid_q, buf_valid_d;
  logic              buf_we_q,    buf_we_d;
  logic [ADDR_W-1:0] buf_addr_q,  buf_addr_d;
  logic [DATA_W-1:0] buf_wdata_q, buf_wdata_d;
  logic [SW-1:0]     starve_q,    starve_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic              mem_we_q,    mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              p1_valid_q,  p1_valid_d;
  logic              p1_cpu_q,    p1_cpu_d;
  logic              p2_valid_q;
  logic              p2_cpu_q;
  logic [DATA_W-1:0] disp_data_q;
  logic              disp_valid_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              cpu_rvalid_q;
  logic              disp_win;
  logic              cpu_win;

  always_comb begin
    disp_win    = rst_n && disp_req && (starve_q < STARVE_LIM);
    cpu_win     = rst_n && !disp_win && buf_valid_q;
    buf_valid_d = buf_valid_q;
    buf_we_d    = buf_we_q;
    buf_addr_d  = buf_addr_q;
    buf_wdata_d = buf_wdata_q;
    starve_d    = '0;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    p1_valid_d  = disp_win || (cpu_win && !buf_we_q);
    p1_cpu_d    = cpu_win;

    if (disp_win) begin
      mem_addr_d = disp_addr;
    end else if (cpu_win) begin
      mem_addr_d  = buf_addr_q;
      mem_we_d    = buf_we_q;
      mem_wdata_d = buf_wdata_q;
    end

    // A pending CPU op only ages while the display is beating it.
    if (buf_valid_q && disp_win) begin
      starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + SW'(1);
    end

    // Capture is gated by the registered busy flag, so a new op cannot win in its capture cycle.
    if (cpu_win) begin
      buf_valid_d = 1'b0;
    end else if (!buf_valid_q && (cpu_wr || cpu_rd)) begin
      buf_valid_d = 1'b1;
      buf_we_d    = cpu_wr;
      buf_addr_d  = cpu_addr;
      buf_wdata_d = cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_valid_q  <= 1'b0;
      buf_we_q     <= 1'b0;
      buf_addr_q   <= '0;
      buf_wdata_q  <= '0;
      starve_q     <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      p1_valid_q   <= 1'b0;
      p1_cpu_q     <= 1'b0;
      p2_valid_q   <= 1'b0;
      p2_cpu_q     <= 1'b0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
    end else begin
      buf_valid_q  <= buf_valid_d;
      buf_we_q     <= buf_we_d;
      buf_addr_q   <= buf_addr_d;
      buf_wdata_q  <= buf_wdata_d;
      starve_q     <= starve_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      p1_valid_q   <= p1_valid_d;
      p1_cpu_q     <= p1_cpu_d;
      p2_valid_q   <= p1_valid_q;
      p2_cpu_q     <= p1_cpu_q;
      disp_valid_q <= p2_valid_q && !p2_cpu_q;
      cpu_rvalid_q <= p2_valid_q && p2_cpu_q;
      if (p2_valid_q && !p2_cpu_q) disp_data_q <= mem_rdata;
      if (p2_valid_q && p2_cpu_q)  cpu_rdata_q <= mem_rdata;
    end
  end

  assign disp_gnt   = disp_win;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign cpu_busy   = buf_valid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vram_arbiter: randomized and directed checks of vram_arbiter against a transaction-level model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_vram_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int SM = 8;
  localparam int VW = 3 * DW + AW + 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_gnt;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          cpu_wr;
  logic          cpu_rd;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_busy;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_data(disp_data), .disp_valid(disp_valid),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment VRAM: synchronous single port, read data valid the cycle after the command.
  logic [DW-1:0] vram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) vram[mem_addr] <= mem_wdata;
    mem_rdata <= vram[mem_addr];
  end

  // Reference model: memory image, buffer contents, starvation age, scheduled read results.
  typedef struct {int cyc; bit disp; logic [DW-1:0] d;} rd_t;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  rd_t           sched[$];
  int            cyc = 0;
  int            starve = 0;
  bit            bv = 0, bwe = 0;
  logic [AW-1:0] baddr = '0;
  logic [DW-1:0] bwd = '0;
  bit            m_dv = 0, m_cv = 0, m_we = 0;
  logic [DW-1:0] m_dd = '0, m_cd = '0, m_wd = '0;
  logic [AW-1:0] m_addr = '0;
  bit            exp_gnt;
  logic [VW-1:0] exp_vec;
  logic [VW-1:0] act_vec;
  int            n_chk = 0;
  int            n_fail = 0;

  assign act_vec = {disp_gnt, disp_valid, disp_data, cpu_busy, cpu_rvalid, cpu_rdata,
                    mem_we, mem_addr, mem_wdata};

  task automatic predict();
    @(negedge clk);
    exp_gnt = rst_n && disp_req && (starve < SM);
    exp_vec = {exp_gnt, m_dv, m_dd, bv, m_cv, m_cd, m_we, m_addr, m_wd};
  endtask

  task automatic advance();
    bit  cw;
    rd_t r;
    if (!rst_n) begin
      starve = 0; bv = 0; bwe = 0; baddr = '0; bwd = '0;
      sched.delete();
      m_dv = 0; m_cv = 0; m_we = 0; m_dd = '0; m_cd = '0; m_wd = '0; m_addr = '0;
    end else begin
      cw = !exp_gnt && bv;
      if (exp_gnt) begin
        r.cyc = cyc + 3; r.disp = 1'b1; r.d = ref_mem[disp_addr];
        sched.push_back(r);
        m_addr = disp_addr; m_we = 0;
      end else if (cw) begin
        m_addr = baddr; m_we = bwe; m_wd = bwd;
        if (bwe) ref_mem[baddr] = bwd;
        else begin
          r.cyc = cyc + 3; r.disp = 1'b0; r.d = ref_mem[baddr];
          sched.push_back(r);
        end
      end else begin
        m_we = 0;
      end
      if (bv && exp_gnt) starve = (starve < SM) ? starve + 1 : SM;
      else starve = 0;
      if (cw) bv = 0;
      else if (!bv && (cpu_wr || cpu_rd)) begin
        bv = 1; bwe = cpu_wr; baddr = cpu_addr; bwd = cpu_wdata;
      end
      m_dv = 0; m_cv = 0;
      while (sched.size() > 0 && sched[0].cyc == cyc + 1) begin
        r = sched.pop_front();
        if (r.disp) begin m_dv = 1; m_dd = r.d; end
        else begin m_cv = 1; m_cd = r.d; end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin predict(); advance(); end
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      disp_req = 1; disp_addr = AW'($urandom); cpu_wr = 1; cpu_rd = 1;
      cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
      predict();
      n_chk++;
      if (act_vec !== exp_vec) begin
        n_fail++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
      end
      advance();
    end
    rst_n = 1; disp_req = 0; cpu_wr = 0; cpu_rd = 0;
  endtask

  task automatic test_disp_stream();
    int nv = 0, first = -1;
    for (int i = 0; i < 10; i++) begin
      disp_req = (i < 5); disp_addr = AW'(i);
      predict();
      n_chk++;
      if (act_vec !== exp_vec) begin
        n_fail++; $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
      end
      if (disp_valid === 1'b1) begin nv++; if (first < 0) first = i; end
      advance();
    end
    disp_req = 0;
    n_chk++;
    if (nv != 5 || first != 3) begin
      n_fail++; $display("FAIL stream_count got=%0d@%0d exp=5@3", nv, first);
    end
  endtask

  task automatic test_cpu_wr_rd();
    int rv_at = -1;
    logic [DW-1:0] rv_d = '0;
    for (int i = 0; i < 11; i++) begin
      cpu_wr = (i == 0); cpu_rd = (i == 2);
      cpu_addr = AW'(16'h0123); cpu_wdata = 8'hA5;
      predict();
      n_chk++;
      if (act_vec !== exp_vec) begin
        n_fail++; $display("FAIL cpu_wr_rd cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
      end
      if (i == 2) begin
        n_chk++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, AW'(16'h0123), 8'hA5}) begin
          n_fail++; $display("FAIL write_issue got=%b/%h/%h exp=1/0123/a5", mem_we, mem_addr, mem_wdata);
        end
      end
      if (cpu_rvalid === 1'b1 && rv_at < 0) begin rv_at = i; rv_d = cpu_rdata; end
      advance();
    end
    cpu_wr = 0; cpu_rd = 0;
    n_chk++;
    if (rv_at != 6 || rv_d !== 8'hA5) begin
      n_fail++; $display("FAIL read_back got=%h@%0d exp=a5@6", rv_d, rv_at);
    end
  endtask

  task automatic test_starve();
    int first = -1, nz = 0;
    bit g;
    idle(6);
    disp_req = 1; disp_addr = AW'(16'h0100);
    for (int i = 0; i < 14; i++) begin
      cpu_wr = (i == 0); cpu_addr = AW'(16'h0200); cpu_wdata = 8'h3C;
      predict();
      n_chk++;
      if (act_vec !== exp_vec) begin
        n_fail++; $display("FAIL starve cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
      end
      if (disp_gnt !== 1'b1) begin nz++; if (first < 0) first = i; end
      if (i == 10) begin
        n_chk++;
        if ({mem_we, mem_addr} !== {1'b1, AW'(16'h0200)}) begin
          n_fail++; $display("FAIL starve_write got=%b/%h exp=1/0200", mem_we, mem_addr);
        end
      end
      g = disp_gnt;
      advance();
      if (g) disp_addr = disp_addr + 1'b1;
    end
    disp_req = 0; cpu_wr = 0;
    n_chk++;
    if (first != 9 || nz != 1) begin
      n_fail++; $display("FAIL starve_count got=%0d@%0d exp=1@9", nz, first);
    end
  endtask

  task automatic test_collision();
    int nwe = 0, nrv = 0;
    idle(4);
    for (int i = 0; i < 10; i++) begin
      cpu_wr = (i <= 1); cpu_rd = (i == 0);
      cpu_addr = (i == 0) ? AW'(16'h0077) : AW'(16'h0078);
      cpu_wdata = (i == 0) ? 8'h5A : 8'hC3;
      predict();
      n_chk++;
      if (act_vec !== exp_vec) begin
        n_fail++; $display("FAIL collision cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
      end
      if (mem_we === 1'b1) begin
        nwe++;
        n_chk++;
        if ({mem_addr, mem_wdata} !== {AW'(16'h0077), 8'h5A}) begin
          n_fail++; $display("FAIL collision_write got=%h/%h exp=0077/5a", mem_addr, mem_wdata);
        end
      end
      if (cpu_rvalid !== 1'b0) nrv++;
      advance();
    end
    cpu_wr = 0; cpu_rd = 0;
    n_chk++;
    if (nwe != 1 || nrv != 0) begin
      n_fail++; $display("FAIL collision_count got=we%0d/rv%0d exp=we1/rv0", nwe, nrv);
    end
  endtask

  task automatic test_reset_mid();
    int nrv = 0;
    idle(4);
    for (int i = 0; i < 9; i++) begin
      cpu_rd = (i == 0); cpu_addr = AW'(16'h0040);
      rst_n = (i != 2);
      predict();
      n_chk++;
      if (act_vec !== exp_vec) begin
        n_fail++; $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
      end
      if (i == 3) begin
        n_chk++;
        if (act_vec !== '0) begin
          n_fail++; $display("FAIL reset_zero got=%h exp=0", act_vec);
        end
      end
      if (cpu_rvalid !== 1'b0) nrv++;
      advance();
    end
    rst_n = 1; cpu_rd = 0;
    n_chk++;
    if (nrv != 0 || cpu_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_after got=rv%0d/busy%b exp=rv0/busy0", nrv, cpu_busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n  = ($urandom_range(0, 79) != 0);
      cpu_wr = ($urandom_range(0, 3) == 0);
      cpu_rd = ($urandom_range(0, 3) == 0);
      cpu_addr  = AW'($urandom_range(0, 15));
      cpu_wdata = DW'($urandom);
      predict();
      n_chk++;
      if (act_vec !== exp_vec) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
      end
      advance();
      if (!(disp_req && !exp_gnt)) begin
        disp_req  = ($urandom_range(0, 2) != 0);
        disp_addr = AW'($urandom_range(0, 15));
      end
    end
    rst_n = 1; disp_req = 0; cpu_wr = 0; cpu_rd = 0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      vram[i]    <= DW'(i * 37 + 5);
      ref_mem[i]  = DW'(i * 37 + 5);
    end
    rst_n = 0; disp_req = 0; disp_addr = '0;
    cpu_wr = 0; cpu_rd = 0; cpu_addr = '0; cpu_wdata = '0;
    predict();
    advance();
    test_reset();
    test_disp_stream();
    test_cpu_wr_rd();
    test_starve();
    test_collision();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL take parameters: ADDR_W, default 13, VRAM word address width; DATA_W, default 8, VRAM word width; STARVE_MAX, default 8, the longest number of consecutive cycles a pending CPU op may lose arbitration.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port disp_req, input, 1 bit: the scan-out fetcher requests a read; it is held until granted.
REQ-005 The block SHALL have port disp_addr, input, ADDR_W bits: the fetch address.
REQ-006 The block SHALL have port disp_gnt, output, 1 bit: combinational; the fetch is accepted this cycle.
REQ-007 The block SHALL have ports disp_data, output, DATA_W bits, and disp_valid, output, 1 bit: registered fetch result plus its 1-cycle strobe.
REQ-008 The block SHALL have ports cpu_wr and cpu_rd, inputs, 1 bit each: 1-cycle CPU write or read strobes.
REQ-009 The block SHALL have ports cpu_addr, input, ADDR_W bits, and cpu_wdata, input, DATA_W bits: the CPU address and write data.
REQ-010 The block SHALL have port cpu_busy, output, 1 bit: registered; high while the CPU op buffer is occupied.
REQ-011 The block SHALL have ports cpu_rdata, output, DATA_W bits, and cpu_rvalid, output, 1 bit: registered CPU read result plus its 1-cycle strobe.
REQ-012 The block SHALL have ports mem_addr, output, ADDR_W bits; mem_we, output, 1 bit; mem_wdata, output, DATA_W bits: the registered single-port VRAM command.
REQ-013 The block SHALL have port mem_rdata, input, DATA_W bits: synchronous VRAM read data, valid one cycle after the command cycle.

Function
REQ-014 The CPU buffer SHALL be one entry (op, addr, wdata); while cpu_busy=0, a cpu_wr or cpu_rd strobe SHALL be captured and cpu_busy SHALL be 1 the next cycle.
REQ-015 Strobes arriving while cpu_busy=1 SHALL be dropped, with no state change.
REQ-016 If cpu_wr and cpu_rd are asserted in the same cycle, the write SHALL be captured and the read dropped.
REQ-017 Arbitration each cycle N: if disp_req=1 and starve_cnt<STARVE_MAX, the display SHALL win with disp_gnt=1; else if the buffer is occupied, the CPU SHALL win; else the cycle SHALL be idle.
REQ-018 starve_cnt SHALL increment in each cycle the buffer is occupied and the CPU loses; it SHALL clear when the CPU wins or the buffer is empty, and it SHALL saturate at STARVE_MAX.
REQ-019 When starve_cnt=STARVE_MAX and disp_req=1, disp_gnt SHALL be 0, the CPU SHALL win, and the fetcher SHALL hold its request.
REQ-020 A winner in cycle N SHALL drive mem_addr/mem_we/mem_wdata in cycle N+1; an idle cycle SHALL drive mem_we=0 and hold mem_addr.
REQ-021 When the CPU wins, the buffer SHALL free, so cpu_busy=0 in N+1; a strobe in N+1 SHALL be captured.
REQ-022 A captured op SHALL never be granted in its capture cycle; the earliest grant SHALL be the cycle after capture.
REQ-023 Reads SHALL track a 2-stage owner/valid pipe: mem_rdata is sampled in N+2, and disp_data/disp_valid or cpu_rdata/cpu_rvalid SHALL be presented in N+3 (latency 3 from grant); CPU writes SHALL produce no strobe.
REQ-024 Back-to-back grants SHALL sustain one VRAM access per cycle.
REQ-025 Read data registers SHALL hold their last value when the valid strobe is low.

Reset
REQ-026 With rst_n=0 at a rising edge, the following SHALL all be 0 next cycle: disp_gnt, disp_valid, disp_data, cpu_busy, cpu_rvalid, cpu_rdata, mem_addr, mem_we, mem_wdata, starve_cnt, the buffer and the pipe valid bits.
REQ-027 Reset mid-operation SHALL discard in-flight reads (no strobe afterwards) and any buffered write (never issued).
REQ-028 While rst_n=0, strobes SHALL be ignored and disp_gnt SHALL be 0.

Verification
REQ-029 Idle CPU, disp_req held with addr 0x0000..0x0004 -> disp_gnt=1 every cycle; disp_valid for 5 consecutive cycles starting 3 cycles after the first grant, data matching the VRAM model.
REQ-030 cpu_wr addr 0x0123 data 0xA5 with no display traffic, then cpu_rd 0x0123 -> mem_we=1 two cycles after the strobe; cpu_rvalid with cpu_rdata=0xA5.
REQ-031 disp_req held continuously with cpu_wr pending, STARVE_MAX=8 -> the write is issued after exactly 8 lost cycles; disp_gnt=0 for that one cycle; display resumes next cycle.
REQ-032 cpu_wr and cpu_rd together, then a second cpu_wr while busy -> only the first write is reached in VRAM; cpu_rvalid is never asserted.
REQ-033 cpu_rd granted, rst_n pulsed low in N+1 -> no cpu_rvalid; all outputs 0; cpu_busy=0 after release.
